// File: rtl/spart_pkg.sv
// Shared constants for the SPART: register addresses, TX/RX state encodings, status bit positions.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TxIdle  = 2'd0;
  localparam tx_state_t TxStart = 2'd1;
  localparam tx_state_t TxData  = 2'd2;
  localparam tx_state_t TxStop  = 2'd3;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t RxIdle  = 2'd0;
  localparam rx_state_t RxStart = 2'd1;
  localparam rx_state_t RxData  = 2'd2;
  localparam rx_state_t RxStop  = 2'd3;

  localparam int unsigned STAT_RDA = 0;
  localparam int unsigned STAT_TBR = 1;
  localparam int unsigned STAT_OVR = 2;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud tick generator: 16-bit down-counter, one-cycle tick at zero, period div+1 clocks.
module spart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div,
  input  logic        load,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == 16'd0);
    cnt_d = cnt_q - 16'd1;
    if (load || tick) cnt_d = div;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spart_core.sv
// SPART: bus-programmable UART with 16x oversampled TX/RX.
// Define SPART_OVR_EN to add the sticky overrun status bit (cleared by a status read).
module spart_core
  import spart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd162,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);

  logic        wr, rd_data, tick, ovr;
  logic [15:0] div_q, div_d;
  logic        load_q, load_d;
  logic [7:0]  status, rd_mux;

  assign wr      = !iorw;
  assign rd_data = iorw && (ioaddr == ADDR_DATA);

  // Divisor writes reload the counter one cycle later, once div_q holds the new byte.
  always_comb begin
    div_d  = div_q;
    load_d = 1'b0;
    if (wr && ioaddr == ADDR_DIV_LO) begin
      div_d[7:0] = databus;
      load_d     = 1'b1;
    end
    if (wr && ioaddr == ADDR_DIV_HI) begin
      div_d[15:8] = databus;
      load_d      = 1'b1;
    end
  end

  spart_baud_gen u_baud (
    .clk  (clk),
    .rst  (rst),
    .div  (div_q),
    .load (load_q),
    .tick (tick)
  );

  tx_state_t       tx_state_q, tx_state_d;
  logic [TW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_buf_q, tx_buf_d;
  logic            tbr_q, tbr_d, txd_q, txd_d;

  // Frames start on a tick so every bit spans exactly OVERSAMPLE tick periods.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_buf_d   = tx_buf_q;
    tbr_d      = tbr_q;
    if (wr && ioaddr == ADDR_DATA && tbr_q) begin
      tx_buf_d = databus;
      tbr_d    = 1'b0;
    end
    case (tx_state_q)
      TxIdle: if (tick && !tbr_q) begin
        tx_state_d = TxStart;
        tx_cnt_d   = '0;
      end
      TxStart: if (tick) begin
        if (tx_cnt_q == LAST) begin
          tx_state_d = TxData;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
        end else tx_cnt_d = tx_cnt_q + TW'(1);
      end
      TxData: if (tick) begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else tx_cnt_d = tx_cnt_q + TW'(1);
      end
      TxStop: if (tick) begin
        if (tx_cnt_q == LAST) begin
          tx_state_d = TxIdle;
          tbr_d      = 1'b1;
        end else tx_cnt_d = tx_cnt_q + TW'(1);
      end
      default: tx_state_d = TxIdle;
    endcase
    txd_d = 1'b1;
    if (tx_state_d == TxStart)     txd_d = 1'b0;
    else if (tx_state_d == TxData) txd_d = tx_buf_d[tx_bit_d];
  end

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [TW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d, rx_buf_q, rx_buf_d;
  logic            rda_q, rda_d, rx_done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_buf_d   = rx_buf_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RxIdle: if (rx_prev_q && !rx_s2_q) begin
        rx_state_d = RxStart;
        rx_cnt_d   = '0;
      end
      RxStart: if (tick) begin
        if (rx_cnt_q == HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RxIdle : RxData;
        end else rx_cnt_d = rx_cnt_q + TW'(1);
      end
      RxData: if (tick) begin
        if (rx_cnt_q == LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + TW'(1);
      end
      RxStop: if (tick) begin
        if (rx_cnt_q == LAST) begin
          rx_state_d = RxIdle;
          rx_done    = rx_s2_q;
        end else rx_cnt_d = rx_cnt_q + TW'(1);
      end
      default: rx_state_d = RxIdle;
    endcase
    // A completing byte beats a simultaneous data read.
    rda_d = rda_q;
    if (rd_data) rda_d = 1'b0;
    if (rx_done) begin
      rx_buf_d = rx_shift_q;
      rda_d    = 1'b1;
    end
  end

`ifdef SPART_OVR_EN
  logic rd_stat, ovr_q, ovr_d;
  assign rd_stat = iorw && (ioaddr == ADDR_STATUS);
  always_comb begin
    ovr_d = ovr_q;
    if (rd_stat)          ovr_d = 1'b0;
    if (rx_done && rda_q) ovr_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) ovr_q <= 1'b0;
    else      ovr_q <= ovr_d;
  end
  assign ovr = ovr_q;
`else
  assign ovr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= DEFAULT_DIV;
      load_q     <= 1'b0;
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_buf_q   <= '0;
      tbr_q      <= 1'b1;
      txd_q      <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_buf_q   <= '0;
      rda_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      load_q     <= load_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_buf_q   <= tx_buf_d;
      tbr_q      <= tbr_d;
      txd_q      <= txd_d;
      rx_s1_q    <= rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      rda_q      <= rda_d;
    end
  end

  always_comb begin
    status           = 8'h00;
    status[STAT_RDA] = rda_q;
    status[STAT_TBR] = tbr_q;
    status[STAT_OVR] = ovr;
    rd_mux           = ioaddr[0] ? status : rx_buf_q;
  end

  assign databus = (iorw && !ioaddr[1]) ? rd_mux : 8'hzz;
  assign rda     = rda_q;
  assign tbr     = tbr_q;
  assign txd     = txd_q;

endmodule

// File: tb/tb_spart_core.sv
// Randomized scoreboard bench for spart_core: serial TX decoder and RX reader pop expected bytes.
module tb_spart_core;

  logic       clk = 1'b0;
  logic       rst, iorw, rxd, db_en;
  logic [1:0] ioaddr;
  logic [7:0] db_drv;
  wire  [7:0] databus;
  logic       rda, tbr, txd;

  assign databus = db_en ? db_drv : 8'hzz;
  always #5 clk = ~clk;

  spart_core dut (
    .clk     (clk),
    .rst     (rst),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (rxd)
  );

`ifdef SPART_OVR_EN
  localparam logic [7:0] OVR_STATUS = 8'h05;
`else
  localparam logic [7:0] OVR_STATUS = 8'h01;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  int         bit_clks = 32;
  logic       tx_mon_en = 1'b0;
  logic       rx_mon_en = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iorw = 1'b0; ioaddr = a; db_drv = d; db_en = 1'b1;
    @(negedge clk);
    iorw = 1'b1; ioaddr = 2'b10; db_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    ioaddr = 2'b10;
  endtask

  task automatic set_div(input int dv);
    bus_wr(2'b10, 8'(dv));
    bus_wr(2'b11, 8'(dv >> 8));
    bit_clks = (dv + 1) * 16;
  endtask

  // Ideal serial frame at the nominal bit period, plus one idle bit.
  task automatic send_rx(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    rxd = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bit_clks) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (bit_clks) @(negedge clk);
    rxd = 1'b1;
    repeat (bit_clks) @(negedge clk);
  endtask

  task automatic wait_tbr(input int limit);
    int n;
    n = 0;
    while (tbr !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("tbr ready", tbr, 1);
  endtask

  task automatic wait_rda(input int limit);
    int n;
    n = 0;
    while (rda !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("rda set", rda, 1);
  endtask

  // TX monitor: decodes txd at bit centres and pops the expected byte.
  logic [7:0] tx_got;
  initial begin
    forever begin
      @(negedge clk);
      if (tx_mon_en && txd === 1'b0) begin
        repeat (bit_clks / 2) @(negedge clk);
        check("tx start bit", txd, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (bit_clks) @(negedge clk);
          tx_got[i] = txd;
        end
        repeat (bit_clks) @(negedge clk);
        check("tx stop bit", txd, 1);
        if (tx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx unexpected frame: got %0h, required none", tx_got);
        end else check("tx byte", tx_got, tx_q.pop_front());
      end
    end
  end

  // RX monitor: whenever rda is up, reads the data register and pops the expected byte.
  logic [7:0] rx_got;
  initial begin
    forever begin
      @(negedge clk);
      if (rx_mon_en && rda === 1'b1) begin
        bus_rd(2'b00, rx_got);
        if (rx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx unexpected byte: got %0h, required none", rx_got);
        end else check("rx byte", rx_got, rx_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  logic [7:0] d, last_good;
  logic [9:0] seq;
  int         n;

  initial begin
    rst = 1'b0; iorw = 1'b1; ioaddr = 2'b10; db_en = 1'b0; db_drv = 8'h00; rxd = 1'b1;
    repeat (4) @(negedge clk);
    check("reset rda", rda, 0);
    check("reset tbr", tbr, 1);
    check("reset txd", txd, 1);
    rst = 1'b1;
    bus_rd(2'b01, d);
    check("reset status", d, 8'h02);
    bus_rd(2'b00, d);
    check("reset rx_buf", d, 8'h00);
    tx_mon_en = 1'b1;

    // Directed A5 frame with a write that must be ignored mid-frame.
    set_div(1);
    tx_q.push_back(8'hA5);
    bus_wr(2'b00, 8'hA5);
    n = 0;
    while (txd !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx start seen", txd, 0);
    check("tbr busy", tbr, 0);
    bus_wr(2'b00, 8'hFF);
    repeat (14) @(negedge clk);
    seq = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx A5 bit %0d", k), txd, seq[k]);
      check("tbr during frame", tbr, 0);
      if (k < 9) repeat (32) @(negedge clk);
    end
    n = 304;
    while (tbr !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("tx frame clocks", n, 320);

    // Directed RX: good byte, glitch, recovery, framing error.
    send_rx(8'h3C, 1'b1);
    wait_rda(4 * bit_clks);
    bus_rd(2'b00, d);
    check("rx 3C", d, 8'h3C);
    check("rda cleared by read", rda, 0);
    @(negedge clk);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch no rda", rda, 0);
    send_rx(8'h96, 1'b1);
    wait_rda(4 * bit_clks);
    bus_rd(2'b00, d);
    check("rx after glitch", d, 8'h96);
    send_rx(8'h55, 1'b0);
    check("framing rda", rda, 0);
    bus_rd(2'b00, d);
    check("framing rx_buf held", d, 8'h96);

    // Two bytes without a read, status sampled while a TX frame is in flight.
    send_rx(8'hA1, 1'b1);
    send_rx(8'h4E, 1'b1);
    tx_q.push_back(8'hC3);
    bus_wr(2'b00, 8'hC3);
    bus_rd(2'b01, d);
    check("overrun status", d, OVR_STATUS);
    bus_rd(2'b00, d);
    check("overrun rx_buf", d, 8'h4E);
    wait_tbr(12 * bit_clks);
    bus_rd(2'b01, d);
    check("status after reads", d, 8'h02);

    // Randomized RX through the monitor.
    last_good = 8'h4E;
    rx_mon_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [7:0] b;
      logic       ok;
      set_div(int'($urandom_range(0, 2)));
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      if (ok) begin
        rx_q.push_back(b);
        last_good = b;
      end
      send_rx(b, ok);
      if (ok) begin
        n = 0;
        while (rx_q.size() != 0 && n < 8 * bit_clks) begin
          @(negedge clk);
          n++;
        end
        check("rx queue drained", rx_q.size(), 0);
      end else begin
        check("rand framing rda", rda, 0);
        bus_rd(2'b00, d);
        check("rand rx_buf held", d, last_good);
      end
    end
    rx_mon_en = 1'b0;

    // Randomized back-to-back TX through the monitor.
    for (int g = 0; g < 2; g++) begin
      wait_tbr(12 * bit_clks);
      set_div(int'($urandom_range(0, 2)));
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b = 8'($urandom);
        wait_tbr(12 * bit_clks);
        tx_q.push_back(b);
        bus_wr(2'b00, b);
      end
      n = 0;
      while (tx_q.size() != 0 && n < 24 * bit_clks) begin
        @(negedge clk);
        n++;
      end
      check("tx queue drained", tx_q.size(), 0);
    end

    // Reset in the middle of an all-zero frame.
    wait_tbr(12 * bit_clks);
    tx_mon_en = 1'b0;
    set_div(0);
    bus_wr(2'b00, 8'h00);
    repeat (100) @(negedge clk);
    check("txd low mid-frame", txd, 0);
    rst = 1'b0;
    @(negedge clk);
    check("txd after mid-frame reset", txd, 1);
    check("tbr after mid-frame reset", tbr, 1);
    rst = 1'b1;
    bus_rd(2'b01, d);
    check("status after mid-frame reset", d, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
